alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side driver of the KGP-RISC ALU: accepts one ALU command (func, a, b) over a
//  valid/ready handshake, drives the ALU's func/a/b inputs and returns the result over a
//  valid/ready response. The ALU shifts at most one bit per pass. For shift ops the
//  sequencer iterates, giving full 0..31-bit shifts with b[4:0] as the amount.
//  Sits between decode/control and the ALU instance in the execute stage.
// PARAMETERS
//  W        32   datapath width (ALU fixed at 32; other values unsupported)
//  SHW      5    shift-amount width, taken from cmd_b[SHW-1:0]
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept (high only in IDLE)
//  cmd_func   in   6   ALU op: 0 add,1 sub,2 and,3 or,4 xor,5 not,6 sla,7 sra,8 srl
//  cmd_a      in   32  operand A
//  cmd_b      in   32  operand B; shift amount for funcs 6-8
//  alu_func   out  6   to ALU func
//  alu_a      out  32  to ALU a
//  alu_b      out  32  to ALU b
//  alu_res    in   32  from ALU res (combinational, same cycle)
//  rsp_valid  out  1   result available, held until accepted
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  32  result
//  rsp_zero   out  1   rsp_data == 0
//  rsp_err    out  1   illegal func (>8); rsp_data = 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. cmd_ready=1 after release. All other outputs = 0.
//  States:
//   IDLE -> EXEC on cmd_valid&cmd_ready, or -> DONE if cmd_func>8 (rsp_err=1, no ALU pass).
//   EXEC -> DONE after the last pass.
//   DONE -> IDLE on rsp_valid&rsp_ready.
//  On accept: register func, a, and b.
//   Non-shift ops: alu_a=cmd_a, alu_b=cmd_b; exactly one EXEC cycle.
//   Shift ops: n = cmd_b[4:0].
//    n=0: one EXEC cycle with alu_b=0, so the ALU returns a unchanged.
//    n>0: n EXEC cycles with alu_b=32'd1. Each cycle, alu_res is loaded into the
//    accumulator, and alu_a takes the accumulator for the next pass. A 5-bit down-counter
//    tracks the remaining passes.
//  alu_func/alu_a/alu_b are registered and change only on accept and during EXEC iterations.
//   Otherwise they hold their last values.
//  rsp_data and rsp_zero are registered from alu_res in the final EXEC cycle.
//  Latency: accept at edge T. rsp_valid rises at T+1+max(n,1) for shifts and T+2 for
//   other ops. For an illegal func, rsp_valid rises at T+1.
//  rsp_valid/rsp_data/rsp_err are stable while rsp_ready=0. They clear on the accepting edge.
//  cmd_ready rises the cycle after the response handshake, so there is no overlap.
//   Back-to-back throughput is one command per (latency+1) cycles.
//  cmd_valid in any state other than IDLE is ignored; the command is not accepted.
//  Arithmetic is modulo 2^32 (ALU wraps). The sequencer adds no flags beyond rsp_zero.
//  Reset mid-EXEC or mid-DONE: the operation is dropped and no response is produced.
//   Outputs return to their reset values.
// STRUCTURE
//  Shared header alu_defs.vh holds:
//   func codes FN_ADD..FN_SRL (0..8), FN_MAX=8;
//   state encodings S_IDLE/S_EXEC/S_DONE;
//   an is_shift(func) macro.
//  Single module. The ALU is instantiated by the parent, not inside the sequencer.
//  The shift-pass counter stays inline; no sub-module is warranted.
// TESTING (bench instantiates the real ALU, checks cycle of rsp_valid)
//  1. ADD a=5 b=7, rsp_ready=1 -> rsp_data=12, rsp_zero=0, rsp_valid at T+2.
//  2. SUB a=3 b=5 -> 0xFFFFFFFE. Then SUB a=9 b=9 -> rsp_data=0, rsp_zero=1.
//  3. SLA a=1 b=4 -> 4 EXEC passes, alu_b=1 each pass, rsp_data=0x10 at T+5.
//     SLA b=0 -> rsp_data=a at T+2.
//  4. SRA a=0x80000000 b=31 -> 0xFFFFFFFF at T+32.
//     SRL a=0x80000000 b=31 -> 0x00000001.
//  5. func=9 -> rsp_err=1, rsp_data=0 at T+1, no ALU pass. rsp_ready low 3 cycles ->
//     rsp_valid/data held stable, cmd_ready=0 throughout.
//  6. rst_n pulsed low during the 3rd pass of SLA b=10 -> no response, cmd_ready=1 after
//     release, next ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the KGP-RISC ALU command sequencer.
package alu_op_sequencer_pkg;

  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;
  localparam int unsigned FW  = 6;

  localparam logic [FW-1:0] FN_ADD = 6'd0;
  localparam logic [FW-1:0] FN_SUB = 6'd1;
  localparam logic [FW-1:0] FN_AND = 6'd2;
  localparam logic [FW-1:0] FN_OR  = 6'd3;
  localparam logic [FW-1:0] FN_XOR = 6'd4;
  localparam logic [FW-1:0] FN_NOT = 6'd5;
  localparam logic [FW-1:0] FN_SLA = 6'd6;
  localparam logic [FW-1:0] FN_SRA = 6'd7;
  localparam logic [FW-1:0] FN_SRL = 6'd8;
  localparam logic [FW-1:0] FN_MAX = FN_SRL;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One accepted command as seen on the request side.
  typedef struct packed {
    logic [FW-1:0] func;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } cmd_t;

  // Shift ops need iterated one-bit ALU passes.
  function automatic logic is_shift(input logic [FW-1:0] func);
    return (func == FN_SLA) || (func == FN_SRA) || (func == FN_SRL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side driver of the KGP-RISC ALU; iterates one-bit ALU shifts into full shifts.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [FW-1:0] cmd_func,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  output logic [FW-1:0] alu_func,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_res,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_zero,
  output logic          rsp_err
);

  state_t         state;
  logic [SHW-1:0] cnt;
  cmd_t           cmd;
  logic [SHW-1:0] shamt;

  // Bundle the request payload and pull out the shift amount.
  always_comb begin
    cmd   = {cmd_func, cmd_a, cmd_b};
    shamt = cmd.b[SHW-1:0];
  end

  // Sequencer FSM; alu_a doubles as the shift accumulator between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd.func > FN_MAX) begin
              // Illegal op: answer immediately, ALU untouched.
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_zero  <= 1'b1;
            end else begin
              state    <= S_EXEC;
              alu_func <= cmd.func;
              alu_a    <= cmd.a;
              if (is_shift(cmd.func)) begin
                if (shamt == '0) begin
                  alu_b <= '0;
                  cnt   <= '0;
                end else begin
                  alu_b <= W'(1);
                  cnt   <= SHW'(shamt - SHW'(1));
                end
              end else begin
                alu_b <= cmd.b;
                cnt   <= '0;
              end
            end
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_res;
            rsp_zero  <= (alu_res == '0);
          end else begin
            alu_a <= alu_res;
            cnt   <= SHW'(cnt - SHW'(1));
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
